// File: rtl/sram_bridge_pkg.sv
// sram_bridge_pkg
//   Shared types and constants for the SRAM-to-sram-like bridge family:
//   the bridge state enum, the bus transfer size encodings and the legal
//   byte-enable patterns of the CPU data port.
//   No ports (package).
package sram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [3:0] WEN_READ = 4'b0000;
  localparam logic [3:0] WEN_B0   = 4'b0001;
  localparam logic [3:0] WEN_B1   = 4'b0010;
  localparam logic [3:0] WEN_B2   = 4'b0100;
  localparam logic [3:0] WEN_B3   = 4'b1000;
  localparam logic [3:0] WEN_H0   = 4'b0011;
  localparam logic [3:0] WEN_H1   = 4'b1100;
  localparam logic [3:0] WEN_WORD = 4'b1111;

endpackage

// File: rtl/sram_wen_decode.sv
// sram_wen_decode
//   Combinational decode of a 4-bit SRAM byte-write-enable into a bus
//   transfer descriptor. Shared by the data- and instruction-side bridges.
//   Ports:
//     wen         in  4  byte write enables, 0000 = read
//     addr_lo     in  2  low CPU address bits (used unchanged for reads)
//     wr          out 1  1 = write
//     size        out 2  SZ_BYTE / SZ_HALF / SZ_WORD
//     addr_lo_out out 2  low address bits to put on the bus
//     illegal     out 1  wen is not one of the legal patterns
module sram_wen_decode
  import sram_bridge_pkg::*;
(
  input  logic [3:0] wen,
  input  logic [1:0] addr_lo,
  output logic       wr,
  output logic [1:0] size,
  output logic [1:0] addr_lo_out,
  output logic       illegal
);

  always_comb begin
    wr          = (wen != WEN_READ);
    size        = SZ_WORD;
    addr_lo_out = 2'd0;
    illegal     = 1'b0;
    unique case (wen)
      WEN_READ: addr_lo_out = addr_lo;
      WEN_B0: begin size = SZ_BYTE; addr_lo_out = 2'd0; end
      WEN_B1: begin size = SZ_BYTE; addr_lo_out = 2'd1; end
      WEN_B2: begin size = SZ_BYTE; addr_lo_out = 2'd2; end
      WEN_B3: begin size = SZ_BYTE; addr_lo_out = 2'd3; end
      WEN_H0: begin size = SZ_HALF; addr_lo_out = 2'd0; end
      WEN_H1: begin size = SZ_HALF; addr_lo_out = 2'd2; end
      WEN_WORD: begin size = SZ_WORD; addr_lo_out = 2'd0; end
      // Unsupported lane mixes degrade to an aligned word write.
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sram_like_bridge.sv
// sram_like_bridge
//   Converts the CPU's single-cycle SRAM-style data port into a handshaked
//   sram-like bus (req/addr_ok/data_ok), one transfer in flight, stalling
//   the pipeline until the transfer completes.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no transfer; a cpu_en captures the request fields
//   REQ   | bus_req high, waiting for bus_addr_ok
//   WAIT  | request accepted, waiting for bus_data_ok
//   DONE  | one cycle with stall released and cpu_rdata presented
//
//   Ports:
//     clk, resetn                     clock, synchronous active-low reset
//     cpu_en/wen/addr/wdata   in      CPU SRAM-style request
//     cpu_rdata, cpu_stall    out     read data and pipeline freeze
//     bus_req/wr/size/addr/wdata out  sram-like request channel
//     bus_addr_ok, bus_data_ok, bus_rdata in  sram-like responses
//   Optional (macro SRAM_BRIDGE_PERF_EN):
//     perf_stall_cnt   out 32  stalled-cycle counter, wraps
//     perf_illegal_wen out 1   sticky, an illegal wen was issued
module sram_like_bridge
  import sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
`ifdef SRAM_BRIDGE_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic              perf_illegal_wen
`endif
);

  state_t state_q, state_d;

  logic       dec_wr;
  logic [1:0] dec_size;
  logic [1:0] dec_addr_lo;
  logic       dec_illegal;
  logic       issue;
  logic       capture;
  logic [DATA_W-1:0] rdata_buf;

  sram_wen_decode u_wen_decode (
    .wen         (cpu_wen),
    .addr_lo     (cpu_addr[1:0]),
    .wr          (dec_wr),
    .size        (dec_size),
    .addr_lo_out (dec_addr_lo),
    .illegal     (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cpu_en)      state_d = REQ;
      REQ:  if (bus_addr_ok) state_d = WAIT;
      WAIT: if (bus_data_ok) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  assign issue   = (state_q == IDLE) && cpu_en;
  // Writes complete with data_ok too, but must not disturb the read buffer.
  assign capture = (state_q == WAIT) && bus_data_ok && !bus_wr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus_wr    <= 1'b0;
      bus_size  <= SZ_BYTE;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata_buf <= '0;
    end else begin
      if (issue) begin
        bus_wr    <= dec_wr;
        bus_size  <= dec_size;
        bus_addr  <= {cpu_addr[ADDR_W-1:2], dec_addr_lo};
        bus_wdata <= cpu_wdata;
      end
      if (capture) rdata_buf <= bus_rdata;
    end
  end

  assign bus_req   = resetn && (state_q == REQ);
  // The DONE cycle is the only one in which the pipeline may advance.
  assign cpu_stall = resetn && cpu_en && (state_q != DONE);
  assign cpu_rdata = rdata_buf;

`ifdef SRAM_BRIDGE_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_stall_cnt   <= 32'd0;
      perf_illegal_wen <= 1'b0;
    end else begin
      if (cpu_stall)             perf_stall_cnt   <= perf_stall_cnt + 32'd1;
      if (issue && dec_illegal)  perf_illegal_wen <= 1'b1;
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
`endif

endmodule

// File: tb/tb_sram_like_bridge.sv
// tb_sram_like_bridge
//   Directed bench for sram_like_bridge. Each transaction is described by
//   its CPU request and the bus timing (addr_ok delay, data_ok delay); the
//   expected stall/request/field waveform is derived from that schedule and
//   checked every cycle by one compare process on the falling edge.
module tb_sram_like_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
`ifdef SRAM_BRIDGE_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic        perf_illegal_wen;
`endif

  always #5 clk = ~clk;

  sram_like_bridge dut (
    .clk         (clk),
    .resetn      (resetn),
    .cpu_en      (cpu_en),
    .cpu_wen     (cpu_wen),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
`ifdef SRAM_BRIDGE_PERF_EN
    ,
    .perf_stall_cnt   (perf_stall_cnt),
    .perf_illegal_wen (perf_illegal_wen)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  logic        cmp_on = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_req = 1'b0;
  logic        exp_wr = 1'b0;
  logic [1:0]  exp_size = 2'd0;
  logic [31:0] exp_addr = 32'd0;
  logic [31:0] exp_wdata = 32'd0;
  logic        chk_rd = 1'b0;
  logic [31:0] model_buf = 32'd0;
  logic        issue_illegal = 1'b0;
  logic [31:0] model_cnt = 32'd0;
  logic        model_ill = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transfer descriptor straight from the byte-enable table.
  task automatic model_decode(input logic [3:0] wen, input logic [1:0] lo,
                              output logic wr, output logic [1:0] size,
                              output logic [1:0] lo_out, output logic ill);
    wr = (wen != 4'b0000);
    ill = 1'b0;
    case (wen)
      4'b0000: begin size = 2'd2; lo_out = lo;    end
      4'b0001: begin size = 2'd0; lo_out = 2'd0;  end
      4'b0010: begin size = 2'd0; lo_out = 2'd1;  end
      4'b0100: begin size = 2'd0; lo_out = 2'd2;  end
      4'b1000: begin size = 2'd0; lo_out = 2'd3;  end
      4'b0011: begin size = 2'd1; lo_out = 2'd0;  end
      4'b1100: begin size = 2'd1; lo_out = 2'd2;  end
      4'b1111: begin size = 2'd2; lo_out = 2'd0;  end
      default: begin size = 2'd2; lo_out = 2'd0; ill = 1'b1; end
    endcase
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cpu_stall", {31'd0, cpu_stall}, {31'd0, exp_stall});
      check("bus_req", {31'd0, bus_req}, {31'd0, exp_req});
      if (exp_req) begin
        check("bus_wr", {31'd0, bus_wr}, {31'd0, exp_wr});
        check("bus_size", {30'd0, bus_size}, {30'd0, exp_size});
        check("bus_addr", bus_addr, exp_addr);
        check("bus_wdata", bus_wdata, exp_wdata);
      end
      if (chk_rd) check("cpu_rdata", cpu_rdata, model_buf);
`ifdef SRAM_BRIDGE_PERF_EN
      check("perf_stall_cnt", perf_stall_cnt, model_cnt);
      check("perf_illegal_wen", {31'd0, perf_illegal_wen}, {31'd0, model_ill});
      model_cnt = !resetn ? 32'd0 : model_cnt + {31'd0, exp_stall};
      model_ill = !resetn ? 1'b0 : (model_ill | issue_illegal);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step();
    cpu_en = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;          // stray response while idle must be ignored
    bus_rdata = $urandom;
    exp_stall = 1'b0;
    exp_req = 1'b0;
    chk_rd = 1'b0;
    issue_illegal = 1'b0;
  endtask

  // da: cycles addr_ok is held low in REQ; dd: extra WAIT cycles before data_ok.
  task automatic txn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input int da, input int dd, input logic [31:0] rd);
    logic m_wr, m_ill;
    logic [1:0] m_size, m_lo;
    model_decode(wen, addr[1:0], m_wr, m_size, m_lo, m_ill);
    step();
    cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b0; chk_rd = 1'b0; issue_illegal = m_ill;
    exp_wr = m_wr; exp_size = m_size; exp_addr = {addr[31:2], m_lo}; exp_wdata = wdata;
    for (int i = 0; i <= da; i++) begin
      step();
      issue_illegal = 1'b0;
      cpu_addr = $urandom;       // registered copy must win
      cpu_wdata = $urandom;
      bus_addr_ok = (i == da);
      bus_data_ok = (i != da);   // data_ok outside WAIT must be ignored
      bus_rdata = $urandom;
      exp_req = 1'b1;
    end
    for (int j = 0; j <= dd; j++) begin
      step();
      bus_addr_ok = 1'b0;
      bus_data_ok = (j == dd);
      bus_rdata = (j == dd) ? rd : $urandom;
      exp_req = 1'b0;
      if (j == dd && !m_wr) model_buf = rd;
    end
    step();
    bus_data_ok = 1'b0;
    exp_stall = 1'b0;
    chk_rd = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; cpu_en = 1'b0; cpu_wen = 4'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;

    // Reset: everything zero, stall held low even with cpu_en asserted.
    @(posedge clk); #1; cpu_en = 1'b1;
    @(negedge clk);
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_req", {31'd0, bus_req}, 32'd0);
    check("rst_wr", {31'd0, bus_wr}, 32'd0);
    check("rst_size", {30'd0, bus_size}, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    step();
    resetn = 1'b1; cpu_en = 1'b0; cmp_on = 1'b1; chk_rd = 1'b1;

    // Read word, addr_ok in cycle 1, data_ok in cycle 3, DONE in cycle 4.
    idle();
    txn(4'b0000, 32'h0000_1000, 32'h0, 0, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("rd_done_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("rd_done_stall", {31'd0, cpu_stall}, 32'd0);
    check("rd_size", {30'd0, bus_size}, 32'd2);
    check("rd_addr", bus_addr, 32'h0000_1000);

    // Byte write on lane 2; buffer keeps the previous read data.
    idle();
    txn(4'b0100, 32'h0000_2003, 32'h00AB_0000, 0, 0, 32'h1357_9BDF);
    @(negedge clk);
    check("bw_addr", bus_addr, 32'h0000_2002);
    check("bw_wr", {31'd0, bus_wr}, 32'd1);
    check("bw_size", {30'd0, bus_size}, 32'd0);
    check("bw_wdata", bus_wdata, 32'h00AB_0000);
    check("bw_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);

    // Backpressure: addr_ok low for 5 REQ cycles.
    idle();
    txn(4'b1100, 32'h0000_4001, 32'h1234_0000, 5, 2, 32'h0);
    idle();

    // Back-to-back reads, cpu_en held through DONE.
    txn(4'b0000, 32'h0000_1000, 32'h0, 0, 0, 32'h1111_1111);
    txn(4'b0000, 32'h0000_1004, 32'h0, 1, 0, 32'h2222_2222);
    @(negedge clk);
    check("b2b_rdata", cpu_rdata, 32'h2222_2222);
    check("b2b_addr", bus_addr, 32'h0000_1004);
    idle();

    // Reset while in WAIT, then a stray data_ok.
    step();
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_5000; cpu_wdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b0; chk_rd = 1'b0;
    exp_wr = 1'b0; exp_size = 2'd2; exp_addr = 32'h0000_5000; exp_wdata = 32'h0;
    step(); bus_addr_ok = 1'b1; exp_req = 1'b1;
    step(); bus_addr_ok = 1'b0; resetn = 1'b0; exp_req = 1'b0; exp_stall = 1'b0; model_buf = 32'h0;
    step(); resetn = 1'b1; cpu_en = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hBAD0_BAD0; chk_rd = 1'b1;
    step(); bus_data_ok = 1'b0;
    @(negedge clk);
    check("rstw_rdata", cpu_rdata, 32'd0);
    check("rstw_stall", {31'd0, cpu_stall}, 32'd0);
    check("rstw_req", {31'd0, bus_req}, 32'd0);

    // Illegal wen 0101: aligned word write.
    txn(4'b0101, 32'h0000_3001, 32'h5555_AAAA, 1, 0, 32'h0);
    @(negedge clk);
    check("ill_size", {30'd0, bus_size}, 32'd2);
    check("ill_addr", bus_addr, 32'h0000_3000);
    check("ill_wr", {31'd0, bus_wr}, 32'd1);
    check("ill_rdata", cpu_rdata, 32'd0);
`ifdef SRAM_BRIDGE_PERF_EN
    check("ill_flag", {31'd0, perf_illegal_wen}, 32'd1);
    check("ill_stall_cnt", perf_stall_cnt, 32'd4);
`endif
    idle();
    idle();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_like_bridge.md
Name: sram_like_bridge

Overview:
- Converts the CPU's always-enabled SRAM-style data port (en/wen/addr/wdata/rdata, single-cycle) into a handshaked sram-like bus (req/addr_ok/data_ok).
- Stalls the pipeline while a transfer is outstanding; one transfer in flight at a time.
- Sits directly downstream of the CPU top's data SRAM port; one instance per port, and the data port is the target.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous reset, active-low.
- cpu_en  in  1  CPU access request, level, held until stall drops.
- cpu_wen  in  4  byte write enables; 0000 means read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data, lane-aligned.
- cpu_rdata  out  32  read data, valid in the cycle cpu_stall is low after a read.
- cpu_stall  out  1  freeze request to the pipeline.
- bus_req  out  1  request valid.
- bus_wr  out  1  1 = write.
- bus_size  out  2  0 = byte, 1 = half, 2 = word.
- bus_addr  out  32  request address.
- bus_wdata  out  32  write data.
- bus_addr_ok  in  1  request accepted this cycle (when bus_req is high).
- bus_data_ok  in  1  data returned or write done.
- bus_rdata  in  32  read data, valid with bus_data_ok.

Behaviour:
- FSM states are IDLE, REQ, WAIT, DONE.
- Reset: state = IDLE, bus_req = 0, bus_wr = 0, bus_size = 0, bus_addr = 0, bus_wdata = 0, rdata buffer = 0, so cpu_rdata = 0.
- cpu_stall is combinational: cpu_en && (state != DONE). Under reset it is 0.
- IDLE, cpu_en = 1: register wr/size/addr/wdata from decode; next state REQ.
- IDLE, cpu_en = 0: stay in IDLE.
- REQ: bus_req = 1 with registered fields held stable. If bus_addr_ok, drop bus_req next cycle and go to WAIT; otherwise stay in REQ.
- WAIT: bus_req = 0. On bus_data_ok, capture bus_rdata (reads only; writes leave the buffer unchanged) and go to DONE.
- DONE: stall low for exactly one cycle, cpu_rdata = buffer, next state IDLE unconditionally. A new or repeated cpu_en is issued from IDLE on the following cycle.
- Minimum latency: 3 cycles of stall plus 1 DONE cycle (request cycle, addr_ok, data_ok, release).
- wen decode:
  - 0000: read, size 2, addr unchanged.
  - 0001 / 0010 / 0100 / 1000: size 0, addr[1:0] = 0 / 1 / 2 / 3.
  - 0011 / 1100: size 1, addr[1:0] = 0 / 2.
  - 1111: size 2, addr[1:0] = 0.
  - Any other pattern: word write with addr[1:0] forced to 0, treated as illegal.
- Bus contract: bus_data_ok arrives no earlier than the cycle after bus_addr_ok. Any data_ok sampled outside WAIT is ignored.
- cpu_addr/cpu_wdata changing while stalled has no effect; the registered copy is authoritative.
- Reset mid-transfer: the FSM returns to IDLE at once. The bus side shares resetn and must also abandon the transfer; a stray data_ok after reset is ignored, since state is IDLE.

Optional Feature:
- Macro SRAM_BRIDGE_PERF_EN.
- Defined: adds port perf_stall_cnt (out, 32): counts cycles with cpu_stall = 1, wraps at 2^32, cleared by reset.
- Also adds perf_illegal_wen (out, 1): sticky flag set on any illegal wen issue, cleared by reset.
- Not defined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package sram_bridge_pkg holds:
  - the state enum (IDLE/REQ/WAIT/DONE);
  - size constants SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2;
  - the legal wen pattern constants.
- Sub-module sram_wen_decode: combinational wen + addr[1:0] in, wr/size/addr_lo/illegal out. It is reusable by the instruction-side bridge.

Test Plan:
- Read word: en = 1, wen = 0000, addr = 0x1000; bus gives addr_ok at cycle 1 and data_ok at cycle 3 with rdata = 0xDEADBEEF. Expect bus_req high on cycle 1 only, size = 2, stall high through cycle 3, DONE at cycle 4 with cpu_rdata = 0xDEADBEEF and stall = 0.
- Byte write: wen = 0100, addr = 0x2003, wdata = 0x00AB0000. Expect bus_wr = 1, size = 0, bus_addr = 0x2002, wdata passed through unchanged.
- Backpressure: addr_ok held low for 5 cycles. Expect bus_req and all fields stable for 5 cycles, then WAIT after addr_ok.
- Back-to-back: cpu_en held through DONE with a new addr 0x1004. Expect IDLE then a new REQ with addr 0x1004; the first rdata appears only in the DONE cycle.
- Reset in WAIT: resetn = 0 for 1 cycle, then data_ok pulses. Expect state IDLE, stall = 0, cpu_rdata = 0, and the pulse ignored.
- Illegal wen 0101 at addr 0x3001. Expect size = 2, bus_addr = 0x3000; with SRAM_BRIDGE_PERF_EN, perf_illegal_wen = 1 and perf_stall_cnt equals the counted stall cycles.
